// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types, constants and decode helper for decoder_onehot_pipe.
// The decode helper works at the widest legal code width (6 bits). Callers
// zero-extend the code and keep only the low 2**IN_W-1 bits of the result.
package decoder_pkg;

    localparam int CNT_W     = 16;
    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = (2 ** MAX_IN_W) - 1;
    // One extra bit so that i+1 never overflows at the widest code width.
    localparam int CODE_W    = MAX_IN_W + 1;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_st_e;

    // One-hot: bit i set when code == i+1. Thermometer: bit i set when code > i.
    // Code 0 gives an all-zero word in both modes.
    function automatic logic [MAX_OUT_W-1:0] decode_word(
        input logic [CODE_W-1:0] code,
        input logic              thermo
    );
        logic [MAX_OUT_W-1:0] word;
        word = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            if (thermo) begin
                word[i] = (code > CODE_W'(i));
            end else begin
                word[i] = (code == CODE_W'(i + 1));
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// decoder_skid_buf: two-entry valid/ready buffer (output register + skid register).
// Upstream ready depends only on the registered occupancy, so there is no
// combinational path from the downstream ready back to the source.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    skid_st_e     r_state;
    skid_st_e     w_state_nxt;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_load_out;
    logic         w_load_skid;
    logic         w_pop_skid;

    assign o_ready    = (r_state != ST_FULL);
    assign o_valid    = (r_state != ST_EMPTY);
    assign o_data     = r_out;
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = o_valid && i_ready;

    // Next occupancy and which data register loads this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Input is blocked here, so only the drain case matters.
                if (w_out_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_pop_skid  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy register; reset discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and skid data; the skid entry moves forward on the draining edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out) begin
                r_out <= i_data;
            end else if (w_pop_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// decoder_onehot_pipe: IN_W-bit code to (2**IN_W-1)-bit one-hot/thermometer word,
// with valid/ready handshakes and a two-entry output buffer.
// REG_IN=1 adds a capture register ahead of the decode (+1 cycle latency).
// Optional macro DECODER_ONEHOT_PIPE_PARITY_EN adds in_par, out_perr, err_sticky.
module decoder_onehot_pipe
    import decoder_pkg::*;
#(
    parameter int  IN_W   = 3,
    parameter int  REG_IN = 0,
    localparam int OUT_W  = (2 ** IN_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_thermo,
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
    input  logic             in_par,
    output logic             out_perr,
    output logic             err_sticky,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_word,
    output logic             out_zero,
    output logic [CNT_W-1:0] cnt_xfer
);

    // Result carried through the buffer; its word width follows IN_W,
    // so it is declared here rather than in the package.
    typedef struct packed {
        logic [OUT_W-1:0] word;
        logic             zero;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
        logic             perr;
`endif
    } res_t;

    logic             w_st_valid;
    logic             w_st_ready;
    logic [IN_W-1:0]  w_st_code;
    logic             w_st_thermo;
    res_t             w_res;
    res_t             w_out_res;
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_cnt_xfer;

`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
    logic w_in_perr;
    logic w_st_perr;
    logic r_err_sticky;

    // Even parity over {thermo, code, par}: any odd count is a mismatch.
    assign w_in_perr = ^{in_thermo, in_code, in_par};
`endif

    generate
        if (REG_IN != 0) begin : g_cap
            logic            r_cap_vld;
            logic [IN_W-1:0] r_cap_code;
            logic            r_cap_thermo;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
            logic            r_cap_perr;
`endif

            // Capture stage: holds its entry until the buffer below accepts it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cap_vld    <= 1'b0;
                    r_cap_code   <= '0;
                    r_cap_thermo <= 1'b0;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
                    r_cap_perr   <= 1'b0;
`endif
                end else if (in_valid && in_ready) begin
                    r_cap_vld    <= 1'b1;
                    r_cap_code   <= in_code;
                    r_cap_thermo <= in_thermo;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
                    r_cap_perr   <= w_in_perr;
`endif
                end else if (w_st_ready) begin
                    r_cap_vld <= 1'b0;
                end
            end

            // Free when empty or when its entry leaves this edge; both terms are registered.
            assign in_ready    = !r_cap_vld || w_st_ready;
            assign w_st_valid  = r_cap_vld;
            assign w_st_code   = r_cap_code;
            assign w_st_thermo = r_cap_thermo;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
            assign w_st_perr   = r_cap_perr;
`endif
        end else begin : g_nocap
            assign in_ready    = w_st_ready;
            assign w_st_valid  = in_valid;
            assign w_st_code   = in_code;
            assign w_st_thermo = in_thermo;
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
            assign w_st_perr   = w_in_perr;
`endif
        end
    endgenerate

    // Decode the staged code; a parity error blanks the word, zero flag still follows the code.
    always_comb begin
        w_res      = '0;
        w_res.word = OUT_W'(decode_word(CODE_W'(w_st_code), w_st_thermo));
        w_res.zero = (w_st_code == '0);
`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
        w_res.perr = w_st_perr;
        if (w_st_perr) begin
            w_res.word = '0;
        end
`endif
    end

    decoder_skid_buf #(
        .W($bits(res_t))
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_st_valid),
        .o_ready (w_st_ready),
        .i_data  (w_res),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_res)
    );

    assign out_word   = w_out_res.word;
    assign out_zero   = w_out_res.zero;
    assign w_out_xfer = out_valid && out_ready;
    assign cnt_xfer   = r_cnt_xfer;

    // Completed output transfers; wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_xfer <= '0;
        end else if (w_out_xfer) begin
            r_cnt_xfer <= r_cnt_xfer + 1'b1;
        end
    end

`ifdef DECODER_ONEHOT_PIPE_PARITY_EN
    assign out_perr   = w_out_res.perr;
    assign err_sticky = r_err_sticky;

    // Sticky error: first accepted code with bad parity, held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (in_valid && in_ready && w_in_perr) begin
            r_err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/decoder_onehot_pipe.md
Name: decoder_onehot_pipe

Overview:
Parametrised, pipelined successor of the team's 3-to-7 code decoder. Converts an IN_W-bit code to a (2^IN_W - 1)-bit word. Code 0 gives all-zero; code n gives bit n-1 set, or bits n-1..0 set in thermometer mode. Carries valid/ready handshakes with a 2-entry skid buffer, so it sits between a code source and its consumer at full throughput under backpressure.

Parameters:
IN_W, 3, input code width; legal range 1..6.
OUT_W, 2**IN_W-1, output width; localparam, not overridable.
REG_IN, 0, when 1 adds a capture register ahead of the decode, giving +1 cycle latency.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  code presented
in_ready  output  1  block can accept a code this cycle
in_code  input  IN_W  code to decode
in_thermo  input  1  0 = one-hot output, 1 = thermometer output; sampled with in_code
out_valid  output  1  out_word holds a valid result
out_ready  input  1  consumer accepts out_word this cycle
out_word  output  OUT_W  decoded word
out_zero  output  1  decoded code was 0 (out_word all-zero)
cnt_xfer  output  16  count of completed output transfers; wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_word=0, out_zero=0, cnt_xfer=0, skid buffer empty. in_ready=1 from the first clock after reset.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Decode:
  - One-hot: out_word[i] = (code == i+1).
  - Thermo: out_word[i] = (code > i).
  - Code 0 gives all-zero in both modes and sets out_zero=1.
  - All arithmetic is unsigned. Compare i+1 at IN_W+1 bits so there is no overflow when IN_W=6.
- Latency with REG_IN=0: result is registered; out_valid rises 1 cycle after the input transfer. With REG_IN=1 it rises after 2 cycles.
- Skid buffer: 2 entries (main output register plus skid register). State machine:
  - EMPTY -> ONE on an input transfer.
  - ONE -> EMPTY on an output transfer with no input transfer.
  - ONE stays ONE on simultaneous input and output transfers.
  - ONE -> FULL on an input transfer while out_ready=0.
  - FULL -> ONE on an output transfer; the skid entry moves to the output register in the same edge.
- in_ready = (state != FULL). It is registered and depends only on state, never combinationally on out_ready.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- out_word and out_zero stay stable while out_valid=1 && out_ready=0.
- REG_IN=1: the capture stage only advances when the downstream stage can accept. The effective depth stays 2 results plus 1 in flight. in_ready must account for an occupied capture stage.
- cnt_xfer increments by 1 on each output transfer. After 0xFFFF it wraps to 0.
- Reset mid-operation: all buffered results are discarded immediately and asynchronously. out_valid drops in the same instant.
- out_ready=1 with out_valid=0 has no effect.

Optional Feature:
Macro DECODER_ONEHOT_PIPE_PARITY_EN.
- When defined:
  - Adds input in_par (1 bit, even parity over {in_thermo,in_code}) and outputs out_perr (1 bit) and err_sticky (1 bit).
  - A parity mismatch on an input transfer forces that result's out_word to 0 and sets out_perr=1 alongside that result.
  - err_sticky sets on the first mismatch and holds until rst.
- When undefined: none of these ports or registers exist, and behaviour is as above.

Decomposition:
- Shared package decoder_pkg holds:
  - the state enum (ST_EMPTY, ST_ONE, ST_FULL)
  - CNT_W=16
  - a function decode_word(code, thermo) parametrised by IN_W
  - the result struct {word, zero[, perr]}
- One sub-module, decoder_skid_buf, holds the 2-entry handshake buffer, parametrised on payload width. The top level does the decode and the optional capture register.

Test Plan:
- Reset then in_code=0..7 back-to-back, in_thermo=0, out_ready=1 -> out_word 0x00,0x01,0x02,0x04,...,0x40, one per cycle after 1-cycle latency; out_zero=1 only for the first; cnt_xfer=8.
- Same sweep with in_thermo=1 -> out_word 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F.
- Backpressure test:
  - Hold out_ready=0 and send codes 3, 5, 6 -> in_ready falls after 2 accepted; code 6 waits.
  - Release out_ready -> outputs 0x04, 0x10, 0x20 in order, with no gaps once flowing.
  - out_word is stable while stalled.
- Random in_valid/out_ready at 50% for 10k codes -> scoreboard matches order and values exactly; in_ready is never 1 in FULL.
- Assert rst with 2 entries held -> out_valid=0 and cnt_xfer=0 immediately; next code 7 gives 0x40 with no stale data.
- Parity and width build with DECODER_ONEHOT_PIPE_PARITY_EN and IN_W=6:
  - Bad parity on code 5 -> out_word=0, out_perr=1, err_sticky=1 persisting.
  - Good code 63 -> bit 62 set.
  - 65536 transfers -> cnt_xfer wraps to 0.
